// File: rtl/bcd_serial_addsub_if.sv
// Handshake bundle for bcd_serial_addsub: operand side (in_*) and result side (out_*).
interface bcd_serial_addsub_if #(
  parameter int DIGITS = 4
);
  localparam int W = 4 * DIGITS;

  logic         in_valid;
  logic         in_ready;
  logic         in_sub;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cy;
  logic         out_err;

  modport master (
    output in_valid, in_sub, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum, out_cy, out_err
  );

  modport slave (
    input  in_valid, in_sub, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, out_cy, out_err
  );
endinterface

// File: rtl/bcd_serial_addsub.sv
// Serial packed-BCD adder/subtractor, one digit per clock, least significant digit first.
// Optional non-BCD digit detection on out_err when INVALID_DIGIT_CHECK_EN is defined.
module bcd_serial_addsub #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  bcd_serial_addsub_if.slave  bus
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Subtraction uses the nines complement of b plus an initial carry of 1.
  function automatic logic [4:0] digit_step(input logic [3:0] a_dig, input logic [3:0] b_dig,
                                            input logic sub, input logic cin);
    logic [3:0] bd;
    logic [4:0] s;
    bd = sub ? (4'd9 - b_dig) : b_dig;
    s  = {1'b0, a_dig} + {1'b0, bd} + {4'd0, cin};
    if (s > 5'd9) begin
      s = s - 5'd10;
      return {1'b1, s[3:0]};
    end else begin
      return {1'b0, s[3:0]};
    end
  endfunction

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic            sub_q, sub_d, c_q, c_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_sum_q, out_sum_d;
  logic            out_cy_q, out_cy_d;

  logic            accept_s, take_s, last_s;
  logic [4:0]      step_s;
  logic [W-1:0]    a_next_s, b_next_s;

  assign accept_s = bus.in_valid & in_ready_q;
  assign take_s   = out_valid_q & bus.out_ready;
  assign last_s   = (cnt_q == CW'(DIGITS - 1));
  assign step_s   = digit_step(a_q[3:0], b_q[3:0], sub_q, c_q);

  // a doubles as the result accumulator: each new digit enters at the top as a digit leaves the bottom
  generate
    if (DIGITS == 1) begin : g_one
      assign a_next_s = step_s[3:0];
      assign b_next_s = 4'd0;
    end else begin : g_many
      assign a_next_s = {step_s[3:0], a_q[W-1:4]};
      assign b_next_s = {4'd0, b_q[W-1:4]};
    end
  endgenerate

`ifdef INVALID_DIGIT_CHECK_EN
  logic err_q, err_d, out_err_q, out_err_d, bad_s;
  assign bad_s       = (a_q[3:0] > 4'd9) | (b_q[3:0] > 4'd9);
  assign bus.out_err = out_err_q;
`else
  assign bus.out_err = 1'b0;
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_cy    = out_cy_q;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept_s) state_d = ST_RUN;  else state_d = ST_IDLE;
      ST_RUN:  if (last_s)   state_d = ST_DONE; else state_d = ST_RUN;
      ST_DONE: if (take_s)   state_d = ST_IDLE; else state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    sub_d     = sub_q;
    c_d       = c_q;
    cnt_d     = cnt_q;
    out_sum_d = out_sum_q;
    out_cy_d  = out_cy_q;
`ifdef INVALID_DIGIT_CHECK_EN
    err_d     = err_q;
    out_err_d = out_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          a_d   = bus.in_a;
          b_d   = bus.in_b;
          sub_d = bus.in_sub;
          c_d   = bus.in_sub;
          cnt_d = '0;
`ifdef INVALID_DIGIT_CHECK_EN
          err_d     = 1'b0;
          out_err_d = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_RUN: begin
        a_d = a_next_s;
        b_d = b_next_s;
        c_d = step_s[4];
`ifdef INVALID_DIGIT_CHECK_EN
        err_d = err_q | bad_s;
`endif
        if (last_s) begin
          cnt_d     = '0;
          out_sum_d = a_next_s;
          out_cy_d  = sub_q ? ~step_s[4] : step_s[4];
`ifdef INVALID_DIGIT_CHECK_EN
          out_err_d = err_q | bad_s;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        cnt_d = '0;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  assign in_ready_d  = (state_d == ST_IDLE);
  assign out_valid_d = (state_d == ST_DONE);

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      sub_q       <= 1'b0;
      c_q         <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cy_q    <= 1'b0;
`ifdef INVALID_DIGIT_CHECK_EN
      err_q       <= 1'b0;
      out_err_q   <= 1'b0;
`endif
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      sub_q       <= sub_d;
      c_q         <= c_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_cy_q    <= out_cy_d;
`ifdef INVALID_DIGIT_CHECK_EN
      err_q       <= err_d;
      out_err_q   <= out_err_d;
`endif
    end
  end
endmodule
